// File: rtl/ex_muldiv_if.sv
// Pipeline-facing signal bundle for the EX-stage multiply/divide unit.
// master = ID/EX side (drives the instruction), slave = ex_muldiv.
interface ex_muldiv_if;
  logic        ex_valid;
  logic [31:0] ex_inst;
  logic [31:0] ex_rs_val;
  logic [31:0] ex_rt_val;
  logic        ex_flush;
  logic        md_stall;
  logic        mf_valid;
  logic [31:0] mf_result;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output ex_valid, ex_inst, ex_rs_val, ex_rt_val, ex_flush,
    input  md_stall, mf_valid, mf_result, hi_o, lo_o
  );

  modport slave (
    input  ex_valid, ex_inst, ex_rs_val, ex_rt_val, ex_flush,
    output md_stall, mf_valid, mf_result, hi_o, lo_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply/divide unit owning the architectural HI/LO registers.
// Signed operations run on magnitudes and are sign-corrected on the final step.
module ex_muldiv #(
  parameter logic [31:0] DIV0_LO = 32'hFFFFFFFF,
  parameter int          ITER    = 32
) (
  input logic     clk,
  input logic     rst_n,
  ex_muldiv_if.slave md
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [5:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_opB;
  logic [63:0] r_acc;
  logic        r_isDiv;
  logic        r_negRes;
  logic        r_negRem;
  logic        r_divZero;

  logic [5:0]  w_funct;
  logic        w_isSpecial;
  logic        w_isMult;
  logic        w_isDiv;
  logic        w_isMD;
  logic        w_isSigned;
  logic        w_isMfhi;
  logic        w_isMflo;
  logic        w_isMthi;
  logic        w_isMtlo;
  logic        w_start;
  logic        w_finish;
  logic        w_stall;
  logic        w_mtEn;
  logic        w_rsNeg;
  logic        w_rtNeg;
  logic [31:0] w_rsMag;
  logic [31:0] w_rtMag;
  logic [32:0] w_mulSum;
  logic [63:0] w_mulNext;
  logic [33:0] w_divTrial;
  logic [63:0] w_divNext;
  logic [63:0] w_accNext;
  logic [63:0] w_prodFinal;
  logic [31:0] w_quoFinal;
  logic [31:0] w_remFinal;

  assign w_funct     = md.ex_inst[5:0];
  assign w_isSpecial = (md.ex_inst[31:26] == 6'h00);
  assign w_isMult    = w_isSpecial & ((w_funct == 6'h18) | (w_funct == 6'h19));
  assign w_isDiv     = w_isSpecial & ((w_funct == 6'h1A) | (w_funct == 6'h1B));
  assign w_isMD      = w_isMult | w_isDiv;
  assign w_isSigned  = ~w_funct[0];
  assign w_isMfhi    = w_isSpecial & (w_funct == 6'h10);
  assign w_isMthi    = w_isSpecial & (w_funct == 6'h11);
  assign w_isMflo    = w_isSpecial & (w_funct == 6'h12);
  assign w_isMtlo    = w_isSpecial & (w_funct == 6'h13);

  // |0x80000000| is 0x80000000 as an unsigned 32-bit value, so magnitudes always fit
  assign w_rsNeg = w_isSigned & md.ex_rs_val[31];
  assign w_rtNeg = w_isSigned & md.ex_rt_val[31];
  assign w_rsMag = w_rsNeg ? -md.ex_rs_val : md.ex_rs_val;
  assign w_rtMag = w_rtNeg ? -md.ex_rt_val : md.ex_rt_val;

  always_comb begin
    w_stateNext = r_state;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_start = md.ex_valid & w_isMD & ~md.ex_flush;
        w_stall = w_start;
        if (w_start) w_stateNext = S_BUSY;
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (md.ex_flush) begin
          w_stateNext = S_IDLE;
        end else if (r_cnt == 6'(ITER - 1)) begin
          w_finish    = 1'b1;
          w_stateNext = S_DONE;
        end
      end
      S_DONE:  w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // acc holds {partial product, multiplier} for mult and {remainder, quotient} for div
  assign w_mulSum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opB} : 33'd0);
  assign w_mulNext  = {w_mulSum, r_acc[31:1]};
  assign w_divTrial = {1'b0, r_acc[63:32], r_acc[31]} - {2'b00, r_opB};
  assign w_divNext  = w_divTrial[33] ? {r_acc[62:0], 1'b0}
                                     : {w_divTrial[31:0], r_acc[30:0], 1'b1};
  assign w_accNext  = r_isDiv ? w_divNext : w_mulNext;

  assign w_prodFinal = r_negRes ? -w_accNext : w_accNext;
  assign w_quoFinal  = r_divZero ? DIV0_LO :
                       (r_negRes ? -w_accNext[31:0] : w_accNext[31:0]);
  assign w_remFinal  = r_negRem ? -w_accNext[63:32] : w_accNext[63:32];

  assign w_mtEn = md.ex_valid & ~md.ex_flush & ~w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_opB     <= '0;
      r_acc     <= '0;
      r_isDiv   <= 1'b0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
    end else if (w_start) begin
      r_cnt     <= '0;
      r_opB     <= w_isDiv ? w_rtMag : w_rsMag;
      r_acc     <= {32'h0, (w_isDiv ? w_rsMag : w_rtMag)};
      r_isDiv   <= w_isDiv;
      r_negRes  <= w_rsNeg ^ w_rtNeg;
      r_negRem  <= w_rsNeg;
      r_divZero <= w_isDiv & (md.ex_rt_val == 32'h0);
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + 6'd1;
      r_acc <= w_accNext;
    end
  end

  // A completing operation and an MTHI/MTLO cannot coincide: MT writes are blocked while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_finish) begin
      if (r_isDiv) begin
        r_hi <= w_remFinal;
        r_lo <= w_quoFinal;
      end else begin
        r_hi <= w_prodFinal[63:32];
        r_lo <= w_prodFinal[31:0];
      end
    end else if (w_mtEn) begin
      if (w_isMthi) r_hi <= md.ex_rs_val;
      if (w_isMtlo) r_lo <= md.ex_rs_val;
    end
  end

  assign md.md_stall  = w_stall;
  assign md.mf_valid  = md.ex_valid & (w_isMfhi | w_isMflo);
  assign md.mf_result = !md.ex_valid ? 32'h0 :
                        w_isMfhi     ? r_hi  :
                        w_isMflo     ? r_lo  : 32'h0;
  assign md.hi_o      = r_hi;
  assign md.lo_o      = r_lo;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus pushes expected HI/LO/stall-length and MF results,
// a negedge monitor pops and compares whenever an operation ends or an MF read is presented.
module tb_ex_muldiv;

  localparam int          ITER    = 32;
  localparam logic [31:0] DIV0_LO = 32'hFFFFFFFF;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stall;
  } mdExp_t;

  logic clk = 1'b0;
  logic rst_n;

  ex_muldiv_if mdIf ();

  ex_muldiv #(.DIV0_LO(DIV0_LO), .ITER(ITER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (mdIf)
  );

  always #5 clk = ~clk;

  mdExp_t      mdQ[$];
  logic [31:0] mfQ[$];
  int          tests  = 0;
  int          errors = 0;
  logic [31:0] modelHi = 32'h0;
  logic [31:0] modelLo = 32'h0;

  function automatic void checkOutput(input string name, input logic [31:0] act,
                                      input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference: whole-word 64-bit arithmetic, SV division truncates toward zero
  function automatic void refMd(input logic [5:0] funct, input logic [31:0] rs,
                                input logic [31:0] rt, output logic [31:0] hi,
                                output logic [31:0] lo);
    longint          sa, sb, sr;
    longint unsigned ua, ub, ur;
    sa = {{32{rs[31]}}, rs};
    sb = {{32{rt[31]}}, rt};
    ua = {32'h0, rs};
    ub = {32'h0, rt};
    hi = modelHi;
    lo = modelLo;
    case (funct)
      F_MULT:  begin sr = sa * sb; hi = sr[63:32]; lo = sr[31:0]; end
      F_MULTU: begin ur = ua * ub; hi = ur[63:32]; lo = ur[31:0]; end
      F_DIV: begin
        if (rt == 32'h0) begin hi = rs; lo = DIV0_LO; end
        else begin sr = sa / sb; lo = sr[31:0]; sr = sa % sb; hi = sr[31:0]; end
      end
      F_DIVU: begin
        if (rt == 32'h0) begin hi = rs; lo = DIV0_LO; end
        else begin ur = ua / ub; lo = ur[31:0]; ur = ua % ub; hi = ur[31:0]; end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issues one instruction from posedge+1 and returns at posedge+1 once it has left EX
  task automatic applyStimulus(input string name, input logic [5:0] op, input logic [5:0] funct,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input int flushAt, input int resetAt);
    mdExp_t      e;
    logic [31:0] h, l;
    bit          isMd;
    int          n;
    isMd = (op == 6'h00) && (funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
    mdIf.ex_valid  = 1'b1;
    mdIf.ex_inst   = {op, 20'($urandom), funct};
    mdIf.ex_rs_val = rs;
    mdIf.ex_rt_val = rt;
    mdIf.ex_flush  = 1'b0;
    if (isMd) begin
      refMd(funct, rs, rt, h, l);
      e.name = name;
      if (resetAt >= 0) begin
        e.hi = 32'h0; e.lo = 32'h0; e.stall = resetAt + 1;
      end else if (flushAt >= 0) begin
        e.hi = modelHi; e.lo = modelLo; e.stall = flushAt + 2;
      end else begin
        e.hi = h; e.lo = l; e.stall = ITER + 1;
      end
      mdQ.push_back(e);
      if (resetAt >= 0) begin
        repeat (resetAt + 1) @(posedge clk);
        #1 rst_n = 1'b0;
        mdIf.ex_valid = 1'b0;
        modelHi = 32'h0;
        modelLo = 32'h0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end else if (flushAt >= 0) begin
        repeat (flushAt + 1) @(posedge clk);
        #1 mdIf.ex_flush = 1'b1;
        @(posedge clk);
        #1 mdIf.ex_flush = 1'b0;
        mdIf.ex_valid = 1'b0;
        @(posedge clk);
        #1;
      end else begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (mdIf.md_stall && n < 200);
        if (mdIf.md_stall) begin
          tests++;
          errors++;
          $display("[TB] FAIL %s_timeout: md_stall still %b after %0d cycles, required 0",
                   name, mdIf.md_stall, n);
        end
        modelHi = h;
        modelLo = l;
        @(posedge clk);
        #1 mdIf.ex_valid = 1'b0;
      end
    end else begin
      if (op == 6'h00 && funct == F_MFHI) mfQ.push_back(modelHi);
      if (op == 6'h00 && funct == F_MFLO) mfQ.push_back(modelLo);
      @(posedge clk);
      #1 mdIf.ex_valid = 1'b0;
      if (op == 6'h00 && funct == F_MTHI) modelHi = rs;
      if (op == 6'h00 && funct == F_MTLO) modelLo = rs;
    end
  endtask

  // Monitor: an operation ends when md_stall falls; MF reads are checked while presented
  initial begin
    bit     prevStall;
    int     stallCnt;
    mdExp_t e;
    prevStall = 1'b0;
    stallCnt  = 0;
    forever begin
      @(negedge clk);
      if (mdIf.md_stall) begin
        stallCnt++;
      end else if (prevStall) begin
        if (mdQ.size() == 0) begin
          tests++;
          errors++;
          $display("[TB] FAIL stray_op: stall of %0d cycles ended, no operation expected",
                   stallCnt);
        end else begin
          e = mdQ.pop_front();
          checkOutput({e.name, "_hi"}, mdIf.hi_o, e.hi);
          checkOutput({e.name, "_lo"}, mdIf.lo_o, e.lo);
          checkOutput({e.name, "_stall_cycles"}, 32'(stallCnt), 32'(e.stall));
        end
        stallCnt = 0;
      end
      prevStall = mdIf.md_stall;
      if (mdIf.mf_valid) begin
        if (mfQ.size() == 0) begin
          tests++;
          errors++;
          $display("[TB] FAIL stray_mf_valid: mf_valid=1 mf_result=%h, no MF expected",
                   mdIf.mf_result);
        end else begin
          checkOutput("mf_result", mdIf.mf_result, mfQ.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [5:0] funct;
    int         sel;
    rst_n          = 1'b0;
    mdIf.ex_valid  = 1'b0;
    mdIf.ex_inst   = 32'h0;
    mdIf.ex_rs_val = 32'h0;
    mdIf.ex_rt_val = 32'h0;
    mdIf.ex_flush  = 1'b0;
    @(negedge clk);
    checkOutput("reset_hi", mdIf.hi_o, 32'h0);
    checkOutput("reset_lo", mdIf.lo_o, 32'h0);
    checkOutput("reset_stall", 32'(mdIf.md_stall), 32'h0);
    checkOutput("reset_mf_valid", 32'(mdIf.mf_valid), 32'h0);
    checkOutput("reset_mf_result", mdIf.mf_result, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    applyStimulus("mult_neg1x2", 6'h00, F_MULT, 32'hFFFFFFFF, 32'h2, -1, -1);
    applyStimulus("multu_max", 6'h00, F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1);
    applyStimulus("mult_min_sq", 6'h00, F_MULT, 32'h80000000, 32'h80000000, -1, -1);
    applyStimulus("div_m7_2", 6'h00, F_DIV, 32'hFFFFFFF9, 32'h2, -1, -1);
    applyStimulus("divu_by0", 6'h00, F_DIVU, 32'h7, 32'h0, -1, -1);
    applyStimulus("div_min_m1", 6'h00, F_DIV, 32'h80000000, 32'hFFFFFFFF, -1, -1);
    applyStimulus("mult_flush10", 6'h00, F_MULT, 32'h3, 32'h5, 10, -1);
    applyStimulus("mult_reset20", 6'h00, F_MULT, 32'h3, 32'h5, -1, 20);
    applyStimulus("mthi", 6'h00, F_MTHI, 32'h1234, 32'h0, -1, -1);
    applyStimulus("mfhi", 6'h00, F_MFHI, 32'h0, 32'h0, -1, -1);
    applyStimulus("mult_6x7", 6'h00, F_MULT, 32'h6, 32'h7, -1, -1);
    applyStimulus("mflo", 6'h00, F_MFLO, 32'h0, 32'h0, -1, -1);

    mdIf.ex_valid = 1'b0;
    mdIf.ex_inst  = {6'h00, 20'h0, F_MULT};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bubble_stall", 32'(mdIf.md_stall), 32'h0);
    end
    @(posedge clk);
    #1 mdIf.ex_valid = 1'b1;
    mdIf.ex_flush = 1'b1;
    @(negedge clk);
    checkOutput("idle_flush_stall", 32'(mdIf.md_stall), 32'h0);
    @(posedge clk);
    #1 mdIf.ex_valid = 1'b0;
    mdIf.ex_flush = 1'b0;

    applyStimulus("b2b_first", 6'h00, F_DIVU, 32'd100, 32'd7, -1, -1);
    applyStimulus("b2b_second", 6'h00, F_MULTU, 32'd12345, 32'd678, -1, -1);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1, 2, 3: begin
          funct = F_MULT + 6'(sel);
          applyStimulus("rand_md", 6'h00, funct, pickOperand(), pickOperand(), -1, -1);
        end
        4: applyStimulus("rand_mthi", 6'h00, F_MTHI, $urandom, 32'h0, -1, -1);
        5: applyStimulus("rand_mtlo", 6'h00, F_MTLO, $urandom, 32'h0, -1, -1);
        6: applyStimulus("rand_mfhi", 6'h00, F_MFHI, 32'h0, 32'h0, -1, -1);
        7: applyStimulus("rand_mflo", 6'h00, F_MFLO, 32'h0, 32'h0, -1, -1);
        8: begin
          funct = F_MULT + 6'($urandom_range(0, 3));
          applyStimulus("rand_flush", 6'h00, funct, pickOperand(), pickOperand(),
                        int'($urandom_range(0, ITER - 1)), -1);
        end
        9:  applyStimulus("rand_nonspecial", 6'h01, F_MULT, $urandom, $urandom, -1, -1);
        10: applyStimulus("rand_other_funct", 6'h00, 6'h20, $urandom, $urandom, -1, -1);
        default: applyStimulus("rand_mflo_b", 6'h00, F_MFLO, 32'h0, 32'h0, -1, -1);
      endcase
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("final_hi", mdIf.hi_o, modelHi);
    checkOutput("final_lo", mdIf.lo_o, modelLo);
    checkOutput("md_queue_left", 32'(mdQ.size()), 32'h0);
    checkOutput("mf_queue_left", 32'(mfQ.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
